note_tone_gen: RTL and testbench

Square-wave tone synthesiser fed by the note-divider stage. It takes the 20-bit note period (`note_div`, in clk cycles) and generates a 50%-duty square wave. It scales the wave by a 4-bit volume into signed 16-bit stereo samples for the downstream audio serialiser. Period changes are applied only at period boundaries, so note switches are glitch-free.

---
 rtl/note_tone_gen_if.sv | 26 ++
 rtl/note_tone_gen.sv | 109 ++++++++++
 tb/tb_note_tone_gen.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/note_tone_gen_if.sv
// Control and sample bus between the note-divider stage, the tone generator
// and the downstream audio serialiser.
interface note_tone_gen_if #(
    parameter int DIV_W    = 20,
    parameter int SAMPLE_W = 16,
    parameter int VOL_W    = 4
);
    logic                       en;
    logic [DIV_W-1:0]           note_div;
    logic [VOL_W-1:0]           vol;
    logic                       mute;
    logic                       tone_out;
    logic                       period_done;
    logic signed [SAMPLE_W-1:0] audio_left;
    logic signed [SAMPLE_W-1:0] audio_right;

    modport master (
        output en, note_div, vol, mute,
        input  tone_out, period_done, audio_left, audio_right
    );

    modport slave (
        input  en, note_div, vol, mute,
        output tone_out, period_done, audio_left, audio_right
    );
endinterface

// File: rtl/note_tone_gen.sv
// Square-wave tone synthesiser: 50%-duty wave from a note period, scaled by
// volume into signed stereo samples. Period changes take effect only at wraps.
module note_tone_gen #(
    parameter int DIV_W    = 20,
    parameter int SAMPLE_W = 16,
    parameter int VOL_W    = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    note_tone_gen_if.slave  bus
);
    localparam int AMP_SHIFT = SAMPLE_W - 1 - VOL_W;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        SILENT
    } state_t;

    state_t              state;
    logic [DIV_W-1:0]    cnt;
    logic [DIV_W-1:0]    div_q;
    logic [DIV_W-1:0]    half;
    logic                tone_q;
    logic                done_q;
    logic [SAMPLE_W-1:0] audio_q;
    logic [SAMPLE_W-1:0] amp;
    logic                div_ok;
    logic                at_half;
    logic                at_wrap;

    assign half    = div_q >> 1;
    assign div_ok  = bus.note_div >= DIV_W'(2);
    assign at_half = cnt == half - 1'b1;
    assign at_wrap = cnt == div_q - 1'b1;
    assign amp     = SAMPLE_W'(bus.vol) << AMP_SHIFT;

    // div_q only ever holds a value >= 2 while in RUN, so half-1 and div_q-1 never underflow there.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            div_q  <= '0;
            tone_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (!bus.en) begin
                state  <= IDLE;
                cnt    <= '0;
                tone_q <= 1'b0;
                div_q  <= bus.note_div;
            end else begin
                case (state)
                    IDLE, SILENT: begin
                        cnt   <= '0;
                        div_q <= bus.note_div;
                        if (div_ok) begin
                            state  <= RUN;
                            tone_q <= 1'b1;
                        end else begin
                            state  <= SILENT;
                            tone_q <= 1'b0;
                        end
                    end
                    RUN: begin
                        if (at_wrap) begin
                            cnt    <= '0;
                            done_q <= 1'b1;
                            div_q  <= bus.note_div;
                            if (div_ok) begin
                                tone_q <= 1'b1;
                            end else begin
                                tone_q <= 1'b0;
                                state  <= SILENT;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                            if (at_half) begin
                                tone_q <= 1'b0;
                            end
                        end
                    end
                    default: begin
                        state  <= IDLE;
                        cnt    <= '0;
                        tone_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Samples follow the registered tone by one cycle; mute zeroes them without touching timing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            audio_q <= '0;
        end else if (state == RUN && !bus.mute) begin
            audio_q <= tone_q ? amp : -amp;
        end else begin
            audio_q <= '0;
        end
    end

    assign bus.tone_out    = tone_q;
    assign bus.period_done = done_q;
    assign bus.audio_left  = audio_q;
    assign bus.audio_right = audio_q;
endmodule

// File: tb/tb_note_tone_gen.sv
// Directed, table-driven bench for note_tone_gen with hand-computed vectors
// plus hand-written sequences for SILENT, en drop, mute and async reset.
module tb_note_tone_gen;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    note_tone_gen_if #(.DIV_W(20), .SAMPLE_W(16), .VOL_W(4)) bus ();

    note_tone_gen #(.DIV_W(20), .SAMPLE_W(16), .VOL_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        en;
        logic [19:0] nd;
        logic [3:0]  vol;
        logic        mute;
        logic        tone;
        logic        done;
        logic [15:0] audio;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(logic rst, logic en, logic [19:0] nd, logic [3:0] vol,
                                logic mute, logic tone, logic done, logic [15:0] audio);
        vec_t v;
        v = '{rst, en, nd, vol, mute, tone, done, audio};
        vecs.push_back(v);
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_output(string tag, logic tone, logic done, logic [15:0] audio);
        chk({tag, " tone_out"}, {31'b0, bus.tone_out}, {31'b0, tone});
        chk({tag, " period_done"}, {31'b0, bus.period_done}, {31'b0, done});
        chk({tag, " audio_left"}, {16'b0, bus.audio_left}, {16'b0, audio});
        chk({tag, " audio_right"}, {16'b0, bus.audio_right}, {16'b0, audio});
    endtask

    task automatic apply_stimulus(logic en, logic [19:0] nd, logic [3:0] vol, logic mute);
        bus.en       = en;
        bus.note_div = nd;
        bus.vol      = vol;
        bus.mute     = mute;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        apply_stimulus(1'b0, 20'd0, 4'd0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // One clock step with inputs applied, followed by a full output check.
    task automatic step(string tag, logic en, logic [19:0] nd, logic [3:0] vol, logic mute,
                        logic tone, logic done, logic [15:0] audio);
        apply_stimulus(en, nd, vol, mute);
        tick();
        check_output(tag, tone, done, audio);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        apply_stimulus(1'b0, 20'd0, 4'd0, 1'b0);

        do_reset();
        check_output("reset", 1'b0, 1'b0, 16'h0000);
        step("idle_hold", 1'b0, 20'd4, 4'd8, 1'b0, 1'b0, 1'b0, 16'h0000);

        // period 4, vol 8
        add(1, 1, 20'd4, 4'd8, 0, 1, 0, 16'h0000);
        add(0, 1, 20'd4, 4'd8, 0, 1, 0, 16'h4000);
        add(0, 1, 20'd4, 4'd8, 0, 0, 0, 16'h4000);
        add(0, 1, 20'd4, 4'd8, 0, 0, 0, 16'hC000);
        add(0, 1, 20'd4, 4'd8, 0, 1, 1, 16'hC000);
        add(0, 1, 20'd4, 4'd8, 0, 1, 0, 16'h4000);
        add(0, 1, 20'd4, 4'd8, 0, 0, 0, 16'h4000);
        add(0, 1, 20'd4, 4'd8, 0, 0, 0, 16'hC000);
        add(0, 1, 20'd4, 4'd8, 0, 1, 1, 16'hC000);
        // period 5, vol 15, switched to 8 at cnt=1
        add(1, 1, 20'd5, 4'd15, 0, 1, 0, 16'h0000);
        add(0, 1, 20'd5, 4'd15, 0, 1, 0, 16'h7800);
        add(0, 1, 20'd8, 4'd15, 0, 0, 0, 16'h7800);
        add(0, 1, 20'd8, 4'd15, 0, 0, 0, 16'h8800);
        add(0, 1, 20'd8, 4'd15, 0, 0, 0, 16'h8800);
        add(0, 1, 20'd8, 4'd15, 0, 1, 1, 16'h8800);
        add(0, 1, 20'd8, 4'd15, 0, 1, 0, 16'h7800);
        add(0, 1, 20'd8, 4'd15, 0, 1, 0, 16'h7800);
        add(0, 1, 20'd8, 4'd15, 0, 1, 0, 16'h7800);
        add(0, 1, 20'd8, 4'd15, 0, 0, 0, 16'h7800);
        add(0, 1, 20'd8, 4'd15, 0, 0, 0, 16'h8800);
        add(0, 1, 20'd8, 4'd15, 0, 0, 0, 16'h8800);
        add(0, 1, 20'd8, 4'd15, 0, 0, 0, 16'h8800);
        add(0, 1, 20'd8, 4'd15, 0, 1, 1, 16'h8800);

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].rst) do_reset();
            step($sformatf("vec%0d", i), vecs[i].en, vecs[i].nd, vecs[i].vol, vecs[i].mute,
                 vecs[i].tone, vecs[i].done, vecs[i].audio);
        end

        // period 6 with note_div=1 applied mid-period: finish, go SILENT, resume
        do_reset();
        step("s3_e1", 1, 20'd6, 4'd4, 0, 1, 0, 16'h0000);
        step("s3_e2", 1, 20'd6, 4'd4, 0, 1, 0, 16'h2000);
        step("s3_e3", 1, 20'd6, 4'd4, 0, 1, 0, 16'h2000);
        step("s3_e4", 1, 20'd1, 4'd4, 0, 0, 0, 16'h2000);
        step("s3_e5", 1, 20'd1, 4'd4, 0, 0, 0, 16'hE000);
        step("s3_e6", 1, 20'd1, 4'd4, 0, 0, 0, 16'hE000);
        step("s3_e7", 1, 20'd1, 4'd4, 0, 0, 1, 16'hE000);
        step("s3_e8", 1, 20'd1, 4'd4, 0, 0, 0, 16'h0000);
        step("s3_e9", 1, 20'd6, 4'd4, 0, 1, 0, 16'h0000);
        step("s3_e10", 1, 20'd6, 4'd4, 0, 1, 0, 16'h2000);

        // en dropped at cnt=2 of an 8-cycle period, then re-raised
        do_reset();
        step("s4_e1", 1, 20'd8, 4'd8, 0, 1, 0, 16'h0000);
        step("s4_e2", 1, 20'd8, 4'd8, 0, 1, 0, 16'h4000);
        step("s4_e3", 1, 20'd8, 4'd8, 0, 1, 0, 16'h4000);
        step("s4_e4", 0, 20'd8, 4'd8, 0, 0, 0, 16'h4000);
        step("s4_e5", 0, 20'd8, 4'd8, 0, 0, 0, 16'h0000);
        step("s4_e6", 1, 20'd8, 4'd8, 0, 1, 0, 16'h0000);
        step("s4_e7", 1, 20'd8, 4'd8, 0, 1, 0, 16'h4000);
        step("s4_e8", 1, 20'd8, 4'd8, 0, 1, 0, 16'h4000);
        step("s4_e9", 1, 20'd8, 4'd8, 0, 1, 0, 16'h4000);
        step("s4_e10", 1, 20'd8, 4'd8, 0, 0, 0, 16'h4000);

        // 3-cycle mute pulse, then vol=0
        do_reset();
        step("s5_e1", 1, 20'd4, 4'd8, 0, 1, 0, 16'h0000);
        step("s5_e2", 1, 20'd4, 4'd8, 0, 1, 0, 16'h4000);
        step("s5_e3", 1, 20'd4, 4'd8, 1, 0, 0, 16'h0000);
        step("s5_e4", 1, 20'd4, 4'd8, 1, 0, 0, 16'h0000);
        step("s5_e5", 1, 20'd4, 4'd8, 1, 1, 1, 16'h0000);
        step("s5_e6", 1, 20'd4, 4'd8, 0, 1, 0, 16'h4000);
        step("s5_e7", 1, 20'd4, 4'd0, 0, 0, 0, 16'h0000);
        step("s5_e8", 1, 20'd4, 4'd0, 0, 0, 0, 16'h0000);
        step("s5_e9", 1, 20'd4, 4'd0, 0, 1, 1, 16'h0000);
        step("s5_e10", 1, 20'd4, 4'd0, 0, 1, 0, 16'h0000);

        // asynchronous reset in the high phase, then restart
        do_reset();
        step("s6_e1", 1, 20'd4, 4'd8, 0, 1, 0, 16'h0000);
        step("s6_e2", 1, 20'd4, 4'd8, 0, 1, 0, 16'h4000);
        #3;
        rst_n = 1'b0;
        #1;
        check_output("s6_async", 1'b0, 1'b0, 16'h0000);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step("s6_r1", 1, 20'd4, 4'd8, 0, 1, 0, 16'h0000);
        step("s6_r2", 1, 20'd4, 4'd8, 0, 1, 0, 16'h4000);
        step("s6_r3", 1, 20'd4, 4'd8, 0, 0, 0, 16'h4000);
        step("s6_r4", 1, 20'd4, 4'd8, 0, 0, 0, 16'hC000);
        step("s6_r5", 1, 20'd4, 4'd8, 0, 1, 1, 16'hC000);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end
endmodule
